// File: rtl/wave_dac_spi.sv
// Waveform-to-DAC bridge: samples the generator output at a programmable rate, saturates to
// 12 bits, buffers in a small FIFO and shifts each sample out as an MCP4921-style SPI frame.
module wave_dac_spi #(
    parameter int FIFO_DEPTH = 4,
    parameter int SRATE_W    = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [3:0]  wstrb_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    input  logic [31:0] wave_i,
    output logic        dac_cs_n_o,
    output logic        dac_sck_o,
    output logic        dac_mosi_o,
    output logic        dac_ldac_n_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_LDAC
    } state_t;

    logic               en_q;
    logic [3:0]         cfg_q;
    logic [SRATE_W-1:0] srate_q;
    logic [7:0]         sckdiv_q;
    logic               ovf_q;

    logic [SRATE_W-1:0] cnt_q;
    logic [SRATE_W-1:0] cnt_d;

    logic [11:0]        fifoMem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wrPtr_q;
    logic [PTR_W-1:0]   rdPtr_q;
    logic [LVL_W-1:0]   level_q;
    logic [LVL_W-1:0]   level_d;

    state_t             state_q;
    logic               csN_q;
    logic               sck_q;
    logic               mosi_q;
    logic               ldacN_q;
    logic [15:0]        shreg_q;
    logic [7:0]         hLat_q;
    logic [7:0]         hCnt_q;
    logic [4:0]         halfCnt_q;

    logic        wrEn;
    logic [1:0]  regSel;
    logic        ctrlWr;
    logic        srateWr;
    logic        sckdivWr;
    logic        statusWr;
    logic        flush;
    logic        tick;
    logic        full;
    logic        empty;
    logic        pop;
    logic        push;
    logic        ovfSet;
    logic        hDone;
    logic [11:0] satSample;
    logic        unusedBits;

    assign unusedBits = ^{addr_i[31:4], addr_i[1:0], wdata_i[31:8]};

    always_comb begin
        wrEn     = |wstrb_i;
        regSel   = addr_i[3:2];
        ctrlWr   = wrEn && (regSel == 2'd0);
        srateWr  = wrEn && (regSel == 2'd1);
        sckdivWr = wrEn && (regSel == 2'd2);
        statusWr = wrEn && (regSel == 2'd3);
        flush    = ctrlWr && wdata_i[1];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            en_q     <= 1'b0;
            cfg_q    <= 4'b0011;
            srate_q  <= SRATE_W'(999);
            sckdiv_q <= 8'd0;
        end else begin
            if (ctrlWr) begin
                en_q  <= wdata_i[0];
                cfg_q <= wdata_i[7:4];
            end
            if (srateWr) begin
                srate_q <= wdata_i[SRATE_W-1:0];
            end
            if (sckdivWr) begin
                sckdiv_q <= wdata_i[7:0];
            end
        end
    end

    // Rate divider: a tick fires on the last count of each SRATE+1 period.
    always_comb begin
        tick  = en_q && (cnt_q == srate_q);
        cnt_d = cnt_q + SRATE_W'(1);
        if (!en_q || srateWr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        satSample = (wave_i > 32'd4095) ? 12'hFFF : wave_i[11:0];
        full      = (level_q == LVL_W'(FIFO_DEPTH));
        empty     = (level_q == '0);
        pop       = (state_q == S_IDLE) && !empty;
        push      = tick && !flush && (!full || pop);
        ovfSet    = tick && !flush && full && !pop;
        level_d   = level_q;
        if (flush) begin
            level_d = '0;
        end else if (push && !pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (pop && !push) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifoMem[wrPtr_q] <= satSample;
        end
    end

    // Flush drops the queue outright; a frame already popped keeps running.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            level_q <= level_d;
            if (flush) begin
                wrPtr_q <= '0;
                rdPtr_q <= '0;
            end else begin
                if (push) begin
                    wrPtr_q <= wrPtr_q + PTR_W'(1);
                end
                if (pop) begin
                    rdPtr_q <= rdPtr_q + PTR_W'(1);
                end
            end
            if (ovfSet) begin
                ovf_q <= 1'b1;
            end else if (statusWr && wdata_i[4]) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign hDone = (hCnt_q == hLat_q);

    // SCK toggles at the end of every half-period; odd half counts are falling edges.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            csN_q     <= 1'b1;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
            ldacN_q   <= 1'b1;
            shreg_q   <= '0;
            hLat_q    <= '0;
            hCnt_q    <= '0;
            halfCnt_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        shreg_q <= {cfg_q, fifoMem[rdPtr_q]};
                        mosi_q  <= cfg_q[3];
                        csN_q   <= 1'b0;
                        hLat_q  <= sckdiv_q;
                        hCnt_q  <= '0;
                        state_q <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (hDone) begin
                        hCnt_q    <= '0;
                        halfCnt_q <= '0;
                        state_q   <= S_SHIFT;
                    end else begin
                        hCnt_q <= hCnt_q + 8'd1;
                    end
                end
                S_SHIFT: begin
                    if (hDone) begin
                        hCnt_q    <= '0;
                        sck_q     <= ~sck_q;
                        halfCnt_q <= halfCnt_q + 5'd1;
                        if (sck_q) begin
                            if (halfCnt_q == 5'd31) begin
                                state_q <= S_HOLD;
                            end else begin
                                shreg_q <= {shreg_q[14:0], 1'b0};
                                mosi_q  <= shreg_q[14];
                            end
                        end
                    end else begin
                        hCnt_q <= hCnt_q + 8'd1;
                    end
                end
                S_HOLD: begin
                    if (hDone) begin
                        hCnt_q  <= '0;
                        csN_q   <= 1'b1;
                        mosi_q  <= 1'b0;
                        ldacN_q <= 1'b0;
                        state_q <= S_LDAC;
                    end else begin
                        hCnt_q <= hCnt_q + 8'd1;
                    end
                end
                S_LDAC: begin
                    if (hDone) begin
                        hCnt_q  <= '0;
                        ldacN_q <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        hCnt_q <= hCnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        rdata_o = '0;
        case (regSel)
            2'd0: begin
                rdata_o[0]   = en_q;
                rdata_o[7:4] = cfg_q;
            end
            2'd1: rdata_o[SRATE_W-1:0] = srate_q;
            2'd2: rdata_o[7:0]         = sckdiv_q;
            default: begin
                rdata_o[LVL_W-1:0] = level_q;
                rdata_o[4]         = ovf_q;
                rdata_o[5]         = (state_q != S_IDLE);
            end
        endcase
    end

    assign dac_cs_n_o   = csN_q;
    assign dac_sck_o    = sck_q;
    assign dac_mosi_o   = mosi_q;
    assign dac_ldac_n_o = ldacN_q;

endmodule
